// File: rtl/display_arbiter.sv
// Round-robin time-sharing of the 7-segment display among N_SRC requesters; registered outputs, grant 1 cycle after req.
// No backpressure: each owner holds the display for DWELL cycles or until it drops req; display data lags grant by 1 cycle.
module display_arbiter #(
    parameter int N_SRC = 4,
    parameter int DWELL = 100_000_000
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      req,
    input  logic [N_SRC*15-1:0]   values,
    input  logic [N_SRC*4-1:0]    dots,
    output logic [N_SRC-1:0]      grant,
    output logic [N_SRC-1:0]      done,
    output logic                  active,
    output logic [14:0]           value_out,
    output logic [3:0]            dot_out
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DWELL - 2);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [N_SRC-1:0]  done_q, done_d;
    logic              active_q, active_d;
    logic [14:0]       value_q, value_d;
    logic [3:0]        dot_q, dot_d;

    logic [14:0]       val_arr [N_SRC];
    logic [3:0]        dot_arr [N_SRC];
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic              rearb;

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign val_arr[i] = values[15*i +: 15];
        assign dot_arr[i] = dots[4*i +: 4];
    end

    // Search starts just after the last owner and ends with the last owner itself.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!win_vld && req[IW'((int'(last_q) + k) % N_SRC)]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(last_q) + k) % N_SRC);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        done_d   = '0;
        rearb    = 1'b0;

        case (state_q)
            IDLE: rearb = 1'b1;
            SHOW: begin
                if (!req[last_q] || cnt_q == CNT_LAST) begin
                    rearb = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // done is registered, so it is raised on entry to the final dwell cycle.
                    if (cnt_q == CNT_PRE) begin
                        done_d[last_q] = 1'b1;
                    end
                end
            end
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            cnt_d = '0;
            if (win_vld) begin
                state_d = SHOW;
                last_d  = win_idx;
                grant_d = N_SRC'(1) << win_idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end

        active_d = (state_d == SHOW);
    end

    always_comb begin
        value_d = '0;
        dot_d   = '0;
        if (state_q == SHOW) begin
            if (val_arr[last_q] > 15'd9999) begin
                value_d = 15'd9999;
                dot_d   = 4'b1111;
            end else begin
                value_d = val_arr[last_q];
                dot_d   = dot_arr[last_q];
            end
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= IW'(N_SRC - 1);
            grant_q  <= '0;
            done_q   <= '0;
            active_q <= 1'b0;
            value_q  <= '0;
            dot_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            active_q <= active_d;
            value_q  <= value_d;
            dot_q    <= dot_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign active    = active_q;
    assign value_out = value_q;
    assign dot_out   = dot_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with N_SRC=4, DWELL=4: ownership-level model checked every cycle plus directed literal checks.
module tb_display_arbiter;

    localparam int N = 4;
    localparam int DW = 4;

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [14:0]   v [N];
    logic [3:0]    d [N];
    logic [N*15-1:0] values;
    logic [N*4-1:0]  dots;
    logic [N-1:0]  grant, done;
    logic          active;
    logic [14:0]   value_out;
    logic [3:0]    dot_out;

    int checks = 0;
    int fails = 0;

    assign values = {v[3], v[2], v[1], v[0]};
    assign dots   = {d[3], d[2], d[1], d[0]};

    always #5 sysclk = ~sysclk;

    display_arbiter #(.N_SRC(N), .DWELL(DW)) dut (
        .sysclk(sysclk), .rst(rst), .req(req), .values(values), .dots(dots),
        .grant(grant), .done(done), .active(active),
        .value_out(value_out), .dot_out(dot_out)
    );

    // Model tracks who owns the display and for how many cycles; owner = -1 means idle.
    typedef struct packed {
        int          owner;
        int          len;
        int          last;
        logic [3:0]  done;
        logic [14:0] val;
        logic [3:0]  dot;
    } mdl_t;

    localparam mdl_t MDL_RST = '{owner: -1, len: 0, last: N-1, done: 4'b0, val: 15'd0, dot: 4'b0};
    mdl_t m = MDL_RST;

    function automatic mdl_t step(mdl_t s, logic [N-1:0] r);
        mdl_t n;
        logic free;
        n = s;
        n.done = '0;
        if (s.owner >= 0) begin
            if (v[s.owner] > 15'd9999) begin
                n.val = 15'd9999;
                n.dot = 4'b1111;
            end else begin
                n.val = v[s.owner];
                n.dot = d[s.owner];
            end
        end else begin
            n.val = '0;
            n.dot = '0;
        end
        free = (s.owner < 0) || !r[s.owner] || (s.len == DW);
        if (!free) begin
            n.len = s.len + 1;
            if (n.len == DW) n.done[s.owner] = 1'b1;
        end else begin
            n.owner = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (s.last + k) % N;
                if (n.owner < 0 && r[c]) n.owner = c;
            end
            if (n.owner >= 0) begin
                n.last = n.owner;
                n.len  = 1;
            end
        end
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge sysclk or posedge rst);
            if (rst) m = MDL_RST;
            else     m = step(m, req);
        end
    end

    initial begin
        logic [N-1:0] eg;
        forever begin
            @(negedge sysclk);
            eg = (m.owner >= 0) ? (N'(1) << m.owner) : '0;
            checks++;
            if (grant !== eg || done !== m.done || active !== (m.owner >= 0) ||
                value_out !== m.val || dot_out !== m.dot) begin
                fails++;
                $display("FAIL model t=%0t: got grant=%b done=%b active=%b value=%0d dot=%b, expected grant=%b done=%b active=%b value=%0d dot=%b",
                         $time, grant, done, active, value_out, dot_out,
                         eg, m.done, (m.owner >= 0), m.val, m.dot);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = '0;
            d[i] = '0;
        end
        v[0] = 15'd1234; d[0] = 4'b0001;
        v[2] = 15'd42;   d[2] = 4'b1000;
        req = 4'b0101;

        // Reset state, then alternation between sources 0 and 2
        cyc(2);
        lit("rst_grant", grant, 0);
        lit("rst_done", done, 0);
        lit("rst_active", active, 0);
        lit("rst_value", value_out, 0);
        lit("rst_dot", dot_out, 0);
        rst = 1'b0;
        cyc(1);
        lit("g0_first", grant, 4'b0001);
        lit("g0_active", active, 1);
        lit("g0_value_lag", value_out, 0);
        cyc(1);
        lit("g0_value", value_out, 1234);
        lit("g0_dot", dot_out, 4'b0001);
        cyc(2);
        lit("g0_last_grant", grant, 4'b0001);
        lit("g0_done", done, 4'b0001);
        cyc(1);
        lit("g2_first", grant, 4'b0100);
        lit("g2_nodone", done, 0);
        lit("g2_value_lag", value_out, 1234);
        cyc(1);
        lit("g2_value", value_out, 42);
        lit("g2_dot", dot_out, 4'b1000);
        cyc(2);
        lit("g2_done", done, 4'b0100);
        cyc(1);
        lit("back_to_0", grant, 4'b0001);

        // Sole requester 3: back-to-back dwells
        req = 4'b1000;
        cyc(1);
        lit("s3_grant", grant, 4'b1000);
        lit("s3_nodone", done, 0);
        cyc(3);
        lit("s3_done1", done, 4'b1000);
        cyc(1);
        lit("s3_regrant", grant, 4'b1000);
        lit("s3_done_clear", done, 0);
        lit("s3_active", active, 1);
        cyc(3);
        lit("s3_done2", done, 4'b1000);

        // Early release by source 1 while source 2 waits
        req = 4'b0110;
        cyc(1);
        lit("er_grant1", grant, 4'b0010);
        cyc(1);
        lit("er_grant1_b", grant, 4'b0010);
        req = 4'b0100;
        cyc(1);
        lit("er_grant2", grant, 4'b0100);
        lit("er_nodone", done, 0);

        // Clamp at and around 9999
        v[0] = 15'd12000; d[0] = 4'b0010; req = 4'b0001;
        cyc(1);
        lit("cl_grant", grant, 4'b0001);
        cyc(1);
        lit("cl_over_val", value_out, 9999);
        lit("cl_over_dot", dot_out, 4'b1111);
        v[0] = 15'd9999;
        cyc(1);
        lit("cl_eq_val", value_out, 9999);
        lit("cl_eq_dot", dot_out, 4'b0010);
        v[0] = 15'd10000;
        cyc(1);
        lit("cl_10000_val", value_out, 9999);
        lit("cl_10000_dot", dot_out, 4'b1111);
        lit("cl_done", done, 4'b0001);

        // Reset mid-dwell of source 2
        req = 4'b0100;
        cyc(1);
        lit("rm_grant2", grant, 4'b0100);
        cyc(1);
        rst = 1'b1;
        #1;
        lit("rm_grant", grant, 0);
        lit("rm_done", done, 0);
        lit("rm_active", active, 0);
        lit("rm_value", value_out, 0);
        lit("rm_dot", dot_out, 0);
        req = 4'b1111;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        lit("rm_first_after", grant, 4'b0001);

        // All requests low from reset, then a short grant ending in IDLE
        rst = 1'b1;
        req = 4'b0000;
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            lit("idle_grant", grant, 0);
            lit("idle_done", done, 0);
            lit("idle_value", value_out, 0);
            lit("idle_dot", dot_out, 0);
        end
        req = 4'b0001;
        cyc(1);
        lit("ig_grant", grant, 4'b0001);
        cyc(1);
        lit("ig_value", value_out, 9999);
        req = 4'b0000;
        cyc(1);
        lit("ig_idle_grant", grant, 0);
        lit("ig_idle_active", active, 0);
        lit("ig_idle_value_lag", value_out, 9999);
        lit("ig_idle_nodone", done, 0);
        cyc(1);
        lit("ig_idle_value", value_out, 0);
        lit("ig_idle_dot", dot_out, 0);
        cyc(2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
